uart_rx_controller: RTL

Memory-mapped UART receive controller for the single-cycle ARM system. It samples the asynchronous `rx` pin, deframes 8N1 bytes with a bit-timing state machine, and buffers them in a FIFO. It exposes data, status and control words to the processor through the MemoryManager UART port. It sits beside `dmem` and the sprite controller on the processor clock domain.

---
 rtl/uart_rx_controller.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_controller.sv
// uart_rx_controller
//   Memory-mapped 8N1 UART receiver. The asynchronous rx pin is synchronized,
//   framed by a bit-timing FSM and received bytes are queued in a small FIFO
//   that the processor reads through a four-word register window.
//
//   Optional feature macro: UART_RX_LED_EN (drives rx_led with a push-triggered
//   activity pulse; when undefined rx_led is tied low).
//
// Ports:
//   clk        processor clock (only clock)
//   reset      asynchronous, active-high reset
//   rx         serial input, idle high
//   address_i  word address; [1:0] select DATA/STATUS/CTRL/reserved
//   MW_i       write strobe, one cycle per store
//   data_i     write data (CTRL: bit0 pop, bit1 clear sticky flags)
//   data_o     combinational read data for address_i
//   rx_led     receive activity indicator
module uart_rx_controller #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [29:0] address_i,
    input  logic        MW_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        rx_led
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    rx_state_t          state_r, state_next_s;
    logic               rx_meta_r, rx_s, rx_prev_r;
    logic [CNT_W-1:0]   clk_cnt_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         shift_r;
    logic               tick_half_s, tick_full_s;
    logic               cnt_reload_s, shift_en_s, byte_ok_s, frame_err_s;

    logic [7:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     fifo_cnt_r;
    logic               not_empty_s, full_s;
    logic               ctrl_wr_s, pop_s, clr_s, push_s, ovr_set_s;
    logic               overrun_r, framing_err_r;
    logic [31:0]        status_s;
    logic               unused_bits_s;

    // Upper address bits and upper CTRL bits carry no function.
    assign unused_bits_s = ^{address_i[29:2], data_i[31:2]};

    // Two-flop synchronizer plus one-cycle history for falling-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
            rx_prev_r <= rx_s;
        end
    end

    assign tick_half_s = (clk_cnt_r == HALF_LAST);
    assign tick_full_s = (clk_cnt_r == FULL_LAST);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a start needs a genuine 1->0 edge on rx_s.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s && rx_prev_r) state_next_s = ST_START;
                else                    state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (tick_half_s) state_next_s = rx_s ? ST_IDLE : ST_DATA;
                else             state_next_s = ST_START;
            end
            ST_DATA: begin
                if (tick_full_s && (bit_cnt_r == 3'd7)) state_next_s = ST_STOP;
                else                                    state_next_s = ST_DATA;
            end
            ST_STOP: begin
                if (tick_full_s) state_next_s = ST_IDLE;
                else             state_next_s = ST_STOP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: counter reload, data-bit shift and stop-bit verdict.
    always_comb begin
        cnt_reload_s = (state_next_s != state_r);
        shift_en_s   = 1'b0;
        byte_ok_s    = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_DATA: begin
                shift_en_s   = tick_full_s;
                cnt_reload_s = tick_full_s;
            end
            ST_STOP: begin
                byte_ok_s   = tick_full_s && rx_s;
                frame_err_s = tick_full_s && !rx_s;
            end
            default: begin
                shift_en_s = 1'b0;
            end
        endcase
    end

    // Bit-timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            if (cnt_reload_s || (state_r == ST_IDLE)) clk_cnt_r <= '0;
            else                                      clk_cnt_r <= clk_cnt_r + CNT_W'(1);
            if (state_r != ST_DATA) bit_cnt_r <= 3'd0;
            else if (shift_en_s)    bit_cnt_r <= bit_cnt_r + 3'd1;
            else                    bit_cnt_r <= bit_cnt_r;
            if (shift_en_s) shift_r <= {rx_s, shift_r[7:1]};
            else            shift_r <= shift_r;
        end
    end

    assign not_empty_s = (fifo_cnt_r != '0);
    assign full_s      = (fifo_cnt_r == DEPTH_CNT);
    assign ctrl_wr_s   = MW_i && (address_i[1:0] == 2'd2);
    assign pop_s       = ctrl_wr_s && data_i[0] && not_empty_s;
    assign clr_s       = ctrl_wr_s && data_i[1];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_s      = byte_ok_s && (!full_s || pop_s);
    assign ovr_set_s   = byte_ok_s && full_s && !pop_s;

    // FIFO storage; contents need no reset since reads are gated by count.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= shift_r;
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W + 1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r     <= 1'b0;
            framing_err_r <= 1'b0;
        end else begin
            if (ovr_set_s)   overrun_r <= 1'b1;
            else if (clr_s)  overrun_r <= 1'b0;
            else             overrun_r <= overrun_r;
            if (frame_err_s) framing_err_r <= 1'b1;
            else if (clr_s)  framing_err_r <= 1'b0;
            else             framing_err_r <= framing_err_r;
        end
    end

    assign status_s = {15'd0, 9'(fifo_cnt_r), 4'd0,
                       framing_err_r, overrun_r, full_s, not_empty_s};

    // Register read mux; reads never change state.
    always_comb begin
        data_o = 32'd0;
        case (address_i[1:0])
            2'd0: begin
                if (not_empty_s) data_o = {24'd0, fifo_mem_r[rd_ptr_r]};
                else             data_o = 32'd0;
            end
            2'd1:    data_o = status_s;
            default: data_o = 32'd0;
        endcase
    end

`ifdef UART_RX_LED_EN
    logic [19:0] led_cnt_r;
    logic        led_r;

    // Activity hold: each push (re)starts a 2^20-cycle high window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_cnt_r <= 20'd0;
            led_r     <= 1'b0;
        end else if (push_s) begin
            led_cnt_r <= 20'hF_FFFF;
            led_r     <= 1'b1;
        end else if (led_r) begin
            if (led_cnt_r == 20'd0) led_r <= 1'b0;
            else                    led_cnt_r <= led_cnt_r - 20'd1;
        end else begin
            led_cnt_r <= led_cnt_r;
        end
    end

    assign rx_led = led_r;
`else
    assign rx_led = 1'b0;
`endif

endmodule
